// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1:3 demultiplexer: destination
// select codes, hold-stage state encoding and a select-validity helper.
package demux_pkg;

  // Destination select codes carried on s and stored with the held word.
  localparam logic [1:0] DEST_Y0  = 2'b00;
  localparam logic [1:0] DEST_Y1  = 2'b01;
  localparam logic [1:0] DEST_Y2  = 2'b10;
  localparam logic [1:0] DEST_BAD = 2'b11;

  // The single hold stage is either empty or holding one word.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // A select is routable unless it is the reserved invalid code.
  function automatic logic dest_is_valid(input logic [1:0] sel);
    return sel != DEST_BAD;
  endfunction

endpackage

// File: rtl/demux_1_3_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear first, otherwise increment until the ceiling is reached.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples its inputs from the same edge regardless of statement order.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/demux_1_3_reg.sv
// Registered 1:3 demultiplexer with valid/ready handshake. One hold stage
// (data + destination) feeds exactly one of three consumers; words sent with
// the invalid select are consumed, dropped and counted.
module demux_1_3_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic             d_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic             y0_valid,
  output logic             y1_valid,
  output logic             y2_valid,
  input  logic             y0_ready,
  input  logic             y1_ready,
  input  logic             y2_ready,
  input  logic             clr_err,
  output logic [CNT_W-1:0] err_cnt
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] hold_data_q;
  logic [WIDTH-1:0] hold_data_d;
  logic [1:0]       hold_dest_q;
  logic [1:0]       hold_dest_d;

  logic             dest_ready;
  logic             in_xfer;
  logic             load;
  logic             drop;
  logic             drain;

  // Ready of the consumer the held word is addressed to.
  always_comb begin
    dest_ready = 1'b0;
    case (hold_dest_q)
      DEST_Y0: dest_ready = y0_ready;
      DEST_Y1: dest_ready = y1_ready;
      DEST_Y2: dest_ready = y2_ready;
      default: dest_ready = 1'b0;
    endcase
  end

  // d_ready depends only on the hold state and the consumer readies, never on
  // d_valid. When full, a word is accepted exactly when the held one leaves.
  assign d_ready = (state_q == ST_EMPTY) ? 1'b1 : dest_ready;
  assign in_xfer = d_valid & d_ready;
  assign load    = in_xfer & dest_is_valid(s);
  assign drop    = in_xfer & ~dest_is_valid(s);
  assign drain   = (state_q == ST_FULL) & dest_ready;

  // Next hold state: a routable input word always (re)loads the stage;
  // otherwise the stage empties when its word drains.
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_dest_d = hold_dest_q;
    if (load) begin
      state_d     = ST_FULL;
      hold_data_d = d;
      hold_dest_d = s;
    end else if (drain) begin
      state_d = ST_EMPTY;
    end
  end

  // Hold stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      // NOTE: the data hold register is reset too, so y0..y2 and any debug
      // view of the stage show zero rather than stale data after reset.
      hold_data_q <= '0;
      hold_dest_q <= DEST_Y0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_dest_q <= hold_dest_d;
    end
  end

  // Output decode: only the addressed port shows valid and data, others idle at zero.
  always_comb begin
    y0       = '0;
    y1       = '0;
    y2       = '0;
    y0_valid = 1'b0;
    y1_valid = 1'b0;
    y2_valid = 1'b0;
    if (state_q == ST_FULL) begin
      case (hold_dest_q)
        DEST_Y0: begin
          y0       = hold_data_q;
          y0_valid = 1'b1;
        end
        DEST_Y1: begin
          y1       = hold_data_q;
          y1_valid = 1'b1;
        end
        DEST_Y2: begin
          y2       = hold_data_q;
          y2_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Count of words dropped for the invalid select.
  sat_counter #(
    .WIDTH (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (drop),
    .clr_i (clr_err),
    .cnt_o (err_cnt)
  );

endmodule

// File: tb/tb_demux_1_3_reg.sv
// Bench for demux_1_3_reg: a directed vector table (routing, backpressure,
// invalid select, drop while draining), hand sequences for saturation and
// asynchronous reset, and a randomized stream against a queue-based model.
module tb_demux_1_3_reg;

  logic       clk;
  logic       rst_n;
  logic [1:0] s;
  logic [7:0] d;
  logic       d_valid;
  logic [2:0] y_rdy;
  logic       clr_err;

  logic       d_ready,  d_ready2;
  logic [7:0] y0, y1, y2;
  logic [7:0] y0b, y1b, y2b;
  logic       y0_valid, y1_valid, y2_valid;
  logic       y0_valid2, y1_valid2, y2_valid2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;

  int total = 0;
  int bad   = 0;

  demux_1_3_reg #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .s(s), .d(d), .d_valid(d_valid), .d_ready(d_ready),
    .y0(y0), .y1(y1), .y2(y2),
    .y0_valid(y0_valid), .y1_valid(y1_valid), .y2_valid(y2_valid),
    .y0_ready(y_rdy[0]), .y1_ready(y_rdy[1]), .y2_ready(y_rdy[2]),
    .clr_err(clr_err), .err_cnt(err_cnt)
  );

  // Second instance with a 2-bit counter shares all inputs.
  demux_1_3_reg #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .s(s), .d(d), .d_valid(d_valid), .d_ready(d_ready2),
    .y0(y0b), .y1(y1b), .y2(y2b),
    .y0_valid(y0_valid2), .y1_valid(y1_valid2), .y2_valid(y2_valid2),
    .y0_ready(y_rdy[0]), .y1_ready(y_rdy[1]), .y2_ready(y_rdy[2]),
    .clr_err(clr_err), .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no end of test, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       v;
    logic [1:0] s;
    logic [7:0] d;
    logic [2:0] rdy;
    logic       clr;
    logic [2:0] ev;
    logic [7:0] ey0, ey1, ey2;
    logic       edr;
    logic [7:0] eerr;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [1:0] sel, input logic [7:0] dat,
                              input logic [2:0] rdy, input logic clr, input logic [2:0] ev,
                              input logic [7:0] ey0, input logic [7:0] ey1, input logic [7:0] ey2,
                              input logic edr, input logic [7:0] eerr);
    vec_t r;
    r.v = v; r.s = sel; r.d = dat; r.rdy = rdy; r.clr = clr; r.ev = ev;
    r.ey0 = ey0; r.ey1 = ey1; r.ey2 = ey2; r.edr = edr; r.eerr = eerr;
    return r;
  endfunction

  typedef struct {
    logic [7:0] data;
    logic [1:0] dest;
  } word_t;

  function automatic logic [7:0] port_data(input logic [1:0] p);
    case (p)
      2'd0:    return y0;
      2'd1:    return y1;
      default: return y2;
    endcase
  endfunction

  vec_t  tbl[20];
  word_t q[$];

  initial begin
    // Expected outputs are those seen in the cycle the row's inputs are driven,
    // i.e. they reflect the rows before it.
    tbl[0]  = mk(1, 2'd0, 8'hA0, 3'b111, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 8'd0);
    tbl[1]  = mk(1, 2'd1, 8'hA1, 3'b111, 0, 3'b001, 8'hA0, 8'h00, 8'h00, 1, 8'd0);
    tbl[2]  = mk(1, 2'd2, 8'hA2, 3'b111, 0, 3'b010, 8'h00, 8'hA1, 8'h00, 1, 8'd0);
    tbl[3]  = mk(0, 2'd0, 8'h00, 3'b111, 0, 3'b100, 8'h00, 8'h00, 8'hA2, 1, 8'd0);
    tbl[4]  = mk(0, 2'd0, 8'h00, 3'b111, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 8'd0);
    tbl[5]  = mk(1, 2'd1, 8'h55, 3'b111, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 8'd0);
    for (int i = 6; i < 10; i++)
      tbl[i] = mk(1, 2'd0, 8'h66, 3'b101, 0, 3'b010, 8'h00, 8'h55, 8'h00, 0, 8'd0);
    tbl[10] = mk(0, 2'd0, 8'h00, 3'b111, 0, 3'b010, 8'h00, 8'h55, 8'h00, 1, 8'd0);
    tbl[11] = mk(0, 2'd0, 8'h00, 3'b111, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 8'd0);
    tbl[12] = mk(1, 2'd3, 8'h11, 3'b111, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 8'd0);
    tbl[13] = mk(1, 2'd3, 8'h12, 3'b111, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 8'd1);
    tbl[14] = mk(1, 2'd3, 8'h13, 3'b111, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 8'd2);
    tbl[15] = mk(1, 2'd3, 8'h14, 3'b111, 1, 3'b000, 8'h00, 8'h00, 8'h00, 1, 8'd3);
    tbl[16] = mk(0, 2'd0, 8'h00, 3'b111, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 8'd0);
    tbl[17] = mk(1, 2'd2, 8'h77, 3'b111, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 8'd0);
    tbl[18] = mk(1, 2'd3, 8'h88, 3'b111, 0, 3'b100, 8'h00, 8'h00, 8'h77, 1, 8'd0);
    tbl[19] = mk(0, 2'd0, 8'h00, 3'b111, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 8'd1);

    rst_n = 1'b0; s = '0; d = '0; d_valid = 1'b0; y_rdy = 3'b111; clr_err = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valids", {29'd0, y2_valid, y1_valid, y0_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_d_ready", d_ready, 1);
    check("rst_err", err_cnt, 0);
    check("rst_y", {8'd0, y2, y1, y0}, 0);

    // Directed vector table.
    foreach (tbl[i]) begin
      @(negedge clk);
      d_valid = tbl[i].v; s = tbl[i].s; d = tbl[i].d; y_rdy = tbl[i].rdy; clr_err = tbl[i].clr;
      #1;
      check($sformatf("row%0d_valids", i), {29'd0, y2_valid, y1_valid, y0_valid}, {29'd0, tbl[i].ev});
      check($sformatf("row%0d_y0", i), y0, tbl[i].ey0);
      check($sformatf("row%0d_y1", i), y1, tbl[i].ey1);
      check($sformatf("row%0d_y2", i), y2, tbl[i].ey2);
      check($sformatf("row%0d_d_ready", i), d_ready, tbl[i].edr);
      check($sformatf("row%0d_err", i), err_cnt, tbl[i].eerr);
    end

    // Saturation: clear, then a run of invalid-select words.
    @(negedge clk);
    d_valid = 1'b0; clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    for (int k = 1; k <= 260; k++) begin
      @(negedge clk);
      d_valid = 1'b1; s = 2'd3; d = 8'(k);
      @(posedge clk);
      #1;
      if (k <= 5 || k >= 254) begin
        check($sformatf("sat2_k%0d", k), err_cnt2, (k < 3) ? k : 3);
        check($sformatf("sat8_k%0d", k), err_cnt, (k < 255) ? k : 255);
      end
      check($sformatf("sat_novalid_k%0d", k), {29'd0, y2_valid, y1_valid, y0_valid}, 0);
    end

    // Reset in the middle of a held, blocked word.
    @(negedge clk);
    d_valid = 1'b1; s = 2'd0; d = 8'hC3; y_rdy = 3'b000;
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    check("pre_rst_y0_valid", y0_valid, 1);
    check("pre_rst_y0", y0, 8'hC3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valids", {29'd0, y2_valid, y1_valid, y0_valid}, 0);
    check("async_rst_y", {8'd0, y2, y1, y0}, 0);
    check("async_rst_err", err_cnt, 0);
    check("async_rst_err2", err_cnt2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_d_ready", d_ready, 1);

    // Randomized stream against an in-order queue model.
    begin
      int sent = 0;
      int got  = 0;
      logic [2:0] exp_v;
      logic       exp_dr;
      for (int cyc = 0; cyc < 500 && got < 16; cyc++) begin
        @(negedge clk);
        y_rdy = 3'($urandom_range(0, 7));
        if (sent < 16 && $urandom_range(0, 3) != 0) begin
          d_valid = 1'b1;
          s = 2'($urandom_range(0, 2));
          d = 8'($urandom);
        end else begin
          d_valid = 1'b0;
        end
        #1;
        exp_v  = (q.size() == 0) ? 3'b000 : (3'b001 << q[0].dest);
        exp_dr = (q.size() == 0) ? 1'b1 : y_rdy[q[0].dest];
        check("stream_valids", {29'd0, y2_valid, y1_valid, y0_valid}, {29'd0, exp_v});
        check("stream_d_ready", d_ready, exp_dr);
        if (q.size() != 0) begin
          check($sformatf("stream_word%0d_data", got), port_data(q[0].dest), q[0].data);
          if (y_rdy[q[0].dest]) begin
            void'(q.pop_front());
            got++;
          end
        end
        if (d_valid && exp_dr) begin
          q.push_back('{data: d, dest: s});
          sent++;
        end
      end
      check("stream_delivered", got, 16);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
